// File: rtl/trees_stream_loader.sv
// Command/stream sequencer feeding trees_ping_pong: tree and feature write strobes, core start/done handshake.
// Optional stall/completion watchdog enabled by defining LOADER_TIMEOUT_EN.
module trees_stream_loader #(
    parameter int N_TREES          = 16,
    parameter int N_NODE_AND_LEAFS = 256,
    parameter int N_FEATURE        = 32,
    parameter int MAX_BURST        = 5000,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          cmd_valid,
    output logic                                          cmd_ready,
    input  logic                                          cmd_mode,
    input  logic [$clog2(MAX_BURST):0]                    cmd_len,
    input  logic [63:0]                                   in_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic                                          load_trees,
    output logic [$clog2(N_NODE_AND_LEAFS)-1:0]           n_node,
    output logic [$clog2(N_TREES)-1:0]                    n_tree,
    output logic [63:0]                                   tree_nodes,
    output logic                                          load_features,
    output logic [$clog2(MAX_BURST*N_FEATURE/2)-1:0]      feature_addr,
    output logic [63:0]                                   features2,
    output logic [$clog2(MAX_BURST):0]                    burst_len,
    output logic                                          start,
    input  logic                                          core_done,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          err
);
    localparam int LEN_W   = $clog2(MAX_BURST) + 1;
    localparam int NODE_W  = $clog2(N_NODE_AND_LEAFS);
    localparam int TREE_W  = $clog2(N_TREES);
    localparam int HF      = N_FEATURE / 2;
    localparam int FADDR_W = $clog2(MAX_BURST * N_FEATURE / 2);

    if ((N_FEATURE % 2) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("trees_stream_loader: N_FEATURE must be even and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_TREES, S_FEAT, S_START, S_WAIT, S_DONE} state_t;

    state_t              state_q;
    logic                fin_q;        // last word accepted; its strobe is on the bus this cycle
    logic [NODE_W-1:0]   node_cnt_q;
    logic [TREE_W-1:0]   tree_cnt_q;
    logic [FADDR_W-1:0]  feat_cnt_q;
    logic                load_trees_q, load_features_q, start_q, done_q, err_q;
    logic [NODE_W-1:0]   n_node_q;
    logic [TREE_W-1:0]   n_tree_q;
    logic [63:0]         tree_nodes_q, features2_q;
    logic [FADDR_W-1:0]  feature_addr_q;
    logic [LEN_W-1:0]    burst_len_q;
    logic                node_last, tree_last, feat_last;

`ifdef LOADER_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES * 64 + 1);
    logic [STALL_W-1:0]  stall_q;
`endif

    assign node_last = (node_cnt_q == NODE_W'(N_NODE_AND_LEAFS - 1));
    assign tree_last = node_last && (tree_cnt_q == TREE_W'(N_TREES - 1));
    assign feat_last = (int'(feat_cnt_q) == int'(burst_len_q) * HF - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            fin_q           <= 1'b0;
            node_cnt_q      <= '0;
            tree_cnt_q      <= '0;
            feat_cnt_q      <= '0;
            load_trees_q    <= 1'b0;
            load_features_q <= 1'b0;
            start_q         <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            n_node_q        <= '0;
            n_tree_q        <= '0;
            tree_nodes_q    <= '0;
            feature_addr_q  <= '0;
            features2_q     <= '0;
            burst_len_q     <= '0;
`ifdef LOADER_TIMEOUT_EN
            stall_q         <= '0;
`endif
        end else begin
            // NOTE: pulses default low here and are raised only by the branch that owns them.
            load_trees_q    <= 1'b0;
            load_features_q <= 1'b0;
            start_q         <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            case (state_q)
                S_IDLE: begin
`ifdef LOADER_TIMEOUT_EN
                    stall_q <= '0;
`endif
                    if (cmd_valid) begin
                        fin_q <= 1'b0;
                        if (!cmd_mode) begin
                            node_cnt_q <= '0;
                            tree_cnt_q <= '0;
                            state_q    <= S_TREES;
                        end else if (cmd_len != '0 && cmd_len <= LEN_W'(MAX_BURST)) begin
                            burst_len_q <= cmd_len;
                            feat_cnt_q  <= '0;
                            state_q     <= S_FEAT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_TREES, S_FEAT: begin
                    if (fin_q) begin
                        fin_q <= 1'b0;
                        if (state_q == S_TREES) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_START;
                            start_q <= 1'b1;
                        end
                    end else if (in_valid) begin
`ifdef LOADER_TIMEOUT_EN
                        stall_q <= '0;
`endif
                        if (state_q == S_TREES) begin
                            load_trees_q <= 1'b1;
                            n_node_q     <= node_cnt_q;
                            n_tree_q     <= tree_cnt_q;
                            tree_nodes_q <= in_data;
                            node_cnt_q   <= node_last ? '0 : node_cnt_q + 1'b1;
                            if (node_last) tree_cnt_q <= tree_cnt_q + 1'b1;
                            fin_q        <= tree_last;
                        end else begin
                            load_features_q <= 1'b1;
                            feature_addr_q  <= feat_cnt_q;
                            features2_q     <= in_data;
                            feat_cnt_q      <= feat_cnt_q + 1'b1;
                            fin_q           <= feat_last;
                        end
                    end
`ifdef LOADER_TIMEOUT_EN
                    else if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        stall_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
`endif
                end
                S_START: begin
`ifdef LOADER_TIMEOUT_EN
                    stall_q <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
`ifdef LOADER_TIMEOUT_EN
                    else if (stall_q == STALL_W'(TIMEOUT_CYCLES * 64 - 1)) begin
                        err_q   <= 1'b1;
                        stall_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
`endif
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Handshake readies are decoded from the state register only, so they never depend on inputs.
    assign cmd_ready     = (state_q == S_IDLE);
    assign in_ready      = (state_q == S_TREES || state_q == S_FEAT) && !fin_q;
    assign busy          = (state_q != S_IDLE);
    assign load_trees    = load_trees_q;
    assign n_node        = n_node_q;
    assign n_tree        = n_tree_q;
    assign tree_nodes    = tree_nodes_q;
    assign load_features = load_features_q;
    assign feature_addr  = feature_addr_q;
    assign features2     = features2_q;
    assign burst_len     = burst_len_q;
    assign start         = start_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_trees_stream_loader.sv
// Self-checking bench for trees_stream_loader: vector table, directed corner cases, randomized commands.
// The timeout scenario runs only when LOADER_TIMEOUT_EN is defined.
module tb_trees_stream_loader;
    localparam int N_TREES   = 2;
    localparam int N_NODE    = 4;
    localparam int N_FEATURE = 4;
    localparam int MAX_BURST = 8;
    localparam int TIMEOUT   = 16;
    localparam int HF        = N_FEATURE / 2;
    localparam int LEN_W     = $clog2(MAX_BURST) + 1;
    localparam int N_TWORDS  = N_TREES * N_NODE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_mode = 1'b0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        core_done = 1'b0;
    logic        cmd_ready, in_ready, load_trees, load_features, start, busy, done, err;
    logic [$clog2(N_NODE)-1:0]               n_node;
    logic [$clog2(N_TREES)-1:0]              n_tree;
    logic [63:0]                             tree_nodes, features2;
    logic [$clog2(MAX_BURST*N_FEATURE/2)-1:0] feature_addr;
    logic [LEN_W-1:0]                        burst_len;

    trees_stream_loader #(
        .N_TREES(N_TREES), .N_NODE_AND_LEAFS(N_NODE), .N_FEATURE(N_FEATURE),
        .MAX_BURST(MAX_BURST), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_len(cmd_len), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .load_trees(load_trees), .n_node(n_node), .n_tree(n_tree),
        .tree_nodes(tree_nodes), .load_features(load_features), .feature_addr(feature_addr),
        .features2(features2), .burst_len(burst_len), .start(start), .core_done(core_done),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int tree; int node; logic [63:0] data; int cyc; } tw_t;
    typedef struct { int addr; logic [63:0] data; } fw_t;
    typedef struct { logic mode; int len; logic exp_err; logic exp_busy; } vec_t;

    tw_t tw_log[$];
    fw_t fw_log[$];
    int  mon_cyc, start_cnt, done_cnt, inr_cnt;
    logic [63:0] words[$];
    int  checks = 0;
    int  errors = 0;

    // Passive monitor: records every write strobe and pulse seen on the outputs.
    always @(negedge clk) begin
        mon_cyc++;
        if (load_trees)    tw_log.push_back('{int'(n_tree), int'(n_node), tree_nodes, mon_cyc});
        if (load_features) fw_log.push_back('{int'(feature_addr), features2});
        if (start)         start_cnt++;
        if (done)          done_cnt++;
        if (in_ready)      inr_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " cmd_ready"}, cmd_ready, 1);
        check({tag, " in_ready"}, in_ready, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " strobes"}, {load_trees, load_features, start, done, err}, 0);
        check({tag, " n_node"}, n_node, 0);
        check({tag, " n_tree"}, n_tree, 0);
        check({tag, " tree_nodes"}, tree_nodes, 0);
        check({tag, " feature_addr"}, feature_addr, 0);
        check({tag, " features2"}, features2, 0);
        check({tag, " burst_len"}, burst_len, 0);
    endtask

    task automatic gen_words(input int n);
        words.delete();
        for (int k = 0; k < n; k++) words.push_back({$urandom, $urandom});
    endtask

    // Called and returns on a negedge; the command is accepted on the posedge in between.
    task automatic send_cmd(input logic mode, input int len);
        int g = 0;
        while (!cmd_ready && g < 200) begin @(negedge clk); g++; end
        if (!cmd_ready) check("cmd_ready wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_len   = LEN_W'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // kind 0: back-to-back, 1: valid every other cycle, 2: random gaps.
    task automatic feed(input int n, input int kind);
        int i = 0;
        int g = 0;
        bit go;
        while (i < n && g < 2000) begin
            case (kind)
                0:       go = 1'b1;
                1:       go = (g % 2 == 0);
                default: go = ($urandom_range(0, 3) != 0);
            endcase
            if (in_ready && go) begin
                in_valid = 1'b1;
                in_data  = words[i];
                i++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            g++;
        end
        in_valid = 1'b0;
        if (i < n) check("feed budget", i, n);
    endtask

    task automatic verify_trees(input int base, input bit back_to_back, input string tag);
        check({tag, " tree count"}, tw_log.size() - base, N_TWORDS);
        for (int k = 0; k < N_TWORDS; k++) begin
            if (base + k < tw_log.size()) begin
                check({tag, " n_tree"}, tw_log[base+k].tree, k / N_NODE);
                check({tag, " n_node"}, tw_log[base+k].node, k % N_NODE);
                check({tag, " tree data"}, tw_log[base+k].data, words[k]);
                if (back_to_back)
                    check({tag, " tree cycle"}, tw_log[base+k].cyc - tw_log[base].cyc, k);
            end
        end
    endtask

    task automatic verify_feats(input int base, input int n, input string tag);
        check({tag, " feat count"}, fw_log.size() - base, n);
        for (int k = 0; k < n; k++) begin
            if (base + k < fw_log.size()) begin
                check({tag, " feature_addr"}, fw_log[base+k].addr, k);
                check({tag, " feature data"}, fw_log[base+k].data, words[k]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   tb, fb, sb, db, ib;

        vecs[0] = '{1'b1, 0,  1'b1, 1'b0};
        vecs[1] = '{1'b1, 9,  1'b1, 1'b0};
        vecs[2] = '{1'b1, 15, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8,  1'b0, 1'b1};
        vecs[4] = '{1'b0, 5,  1'b0, 1'b1};
        vecs[5] = '{1'b1, 1,  1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Tree load, back-to-back words 0x10..0x17.
        words.delete();
        for (int k = 0; k < N_TWORDS; k++) words.push_back(64'h10 + 64'(k));
        tb = tw_log.size(); sb = start_cnt;
        send_cmd(1'b0, 0);
        feed(N_TWORDS, 0);
        check("trees last strobe", {load_trees, n_tree, n_node}, {1'b1, 1'b1, 2'd3});
        check("trees last data", tree_nodes, 64'h17);
        check("trees done early", done, 0);
        @(negedge clk);
        check("trees done", done, 1);
        check("trees busy in done", busy, 1);
        @(negedge clk);
        check("trees done width", done, 0);
        check("trees idle", busy, 0);
        verify_trees(tb, 1'b1, "trees");
        check("trees no start", start_cnt - sb, 0);

        // Feature load, len 3, valid every other cycle.
        gen_words(6);
        fb = fw_log.size(); sb = start_cnt; db = done_cnt;
        send_cmd(1'b1, 3);
        feed(6, 1);
        check("feat last strobe", {load_features, feature_addr}, {1'b1, 4'd5});
        check("feat last data", features2, words[5]);
        @(negedge clk);
        check("feat start", start, 1);
        check("feat burst_len", burst_len, 3);
        check("feat in_ready in start", in_ready, 0);
        @(negedge clk);
        check("feat start width", start, 0);
        repeat (9) @(negedge clk);
        check("feat waiting", {busy, done}, 2'b10);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("feat done", done, 1);
        @(negedge clk);
        check("feat idle", {busy, done}, 2'b00);
        check("feat burst_len held", burst_len, 3);
        verify_feats(fb, 6, "feat");
        check("feat start count", start_cnt - sb, 1);
        check("feat done count", done_cnt - db, 1);

        // Command vector table: illegal lengths raise err, legal ones are accepted (then reset away).
        foreach (vecs[i]) begin
            fb = fw_log.size(); sb = start_cnt; ib = inr_cnt;
            send_cmd(vecs[i].mode, vecs[i].len);
            check($sformatf("vec%0d err", i), err, vecs[i].exp_err);
            check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].exp_busy);
            if (vecs[i].exp_busy && vecs[i].mode)
                check($sformatf("vec%0d burst_len", i), burst_len, vecs[i].len);
            @(negedge clk);
            check($sformatf("vec%0d err width", i), err, 0);
            if (vecs[i].exp_busy) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check($sformatf("vec%0d reset", i), busy, 0);
            end else begin
                check($sformatf("vec%0d quiet", i),
                      (fw_log.size() - fb) + (start_cnt - sb) + (inr_cnt - ib), 0);
            end
        end

        // core_done during S_FEAT is ignored; cmd_valid during S_WAIT is not accepted.
        gen_words(4);
        fb = fw_log.size(); db = done_cnt;
        send_cmd(1'b1, 2);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        feed(4, 1);
        check("early done ignored strobe", {load_features, feature_addr}, {1'b1, 4'd3});
        @(negedge clk);
        check("early done start", {start, done}, 2'b10);
        cmd_valid = 1'b1;
        cmd_mode  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("wait cmd_ready", {cmd_ready, busy, in_ready}, 3'b010);
        end
        cmd_valid = 1'b0;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("wait done", done, 1);
        @(negedge clk);
        check("no second cmd", {busy, in_ready}, 2'b00);
        check("early done count", done_cnt - db, 1);
        verify_feats(fb, 4, "earlydone");

        // Reset after the third feature word, then a fresh tree load restarts at (0,0).
        gen_words(4);
        sb = start_cnt; db = done_cnt;
        send_cmd(1'b1, 2);
        feed(3, 0);
        check("pre-reset strobe", {load_features, feature_addr}, {1'b1, 4'd2});
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("midreset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset no start/done", (start_cnt - sb) + (done_cnt - db), 0);
        gen_words(N_TWORDS);
        tb = tw_log.size();
        send_cmd(1'b0, 0);
        feed(N_TWORDS, 2);
        @(negedge clk);
        check("restart done", done, 1);
        @(negedge clk);
        verify_trees(tb, 1'b0, "restart");

        // Randomized commands against the address/ordering model.
        for (int it = 0; it < 20; it++) begin
            logic mode;
            int   len, n, kind, dly;
            mode = 1'($urandom_range(0, 1));
            len  = $urandom_range(1, MAX_BURST);
            kind = $urandom_range(0, 2);
            n    = mode ? len * HF : N_TWORDS;
            gen_words(n);
            tb = tw_log.size(); fb = fw_log.size(); sb = start_cnt;
            send_cmd(mode, len);
            feed(n, kind);
            @(negedge clk);
            if (mode) begin
                check("rand start", start, 1);
                check("rand burst_len", burst_len, len);
                dly = $urandom_range(0, 20);
                repeat (dly) @(negedge clk);
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
                check("rand feat done", done, 1);
                verify_feats(fb, n, "rand");
                check("rand start count", start_cnt - sb, 1);
            end else begin
                check("rand tree done", done, 1);
                verify_trees(tb, kind == 0, "rand");
                check("rand no start", start_cnt - sb, 0);
            end
            @(negedge clk);
            check("rand idle", busy, 0);
        end

`ifdef LOADER_TIMEOUT_EN
        // Stall after two words: err once 16 consecutive idle cycles have elapsed.
        gen_words(4);
        sb = start_cnt;
        send_cmd(1'b1, 2);
        feed(2, 0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (k == TIMEOUT - 1) check("timeout not yet", err, 0);
        end
        check("timeout err", err, 1);
        check("timeout idle", cmd_ready, 1);
        @(negedge clk);
        check("timeout err width", err, 0);
        check("timeout no start", start_cnt - sb, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
